// File: rtl/slot_credit_ledger.sv
// slot_credit_ledger: credit ledger for the slot machine.
// Loads a deposit, debits the stake for each spin, waits for the judge
// result and credits bet*multiplier on a win.
// Optional macro CREDIT_SAT_EN: on payout overflow the credit saturates to
// all-ones. When it is undefined the credit wraps modulo 2^CREDIT_W.
module slot_credit_ledger #(
  parameter int CREDIT_W = 8,
  parameter int BET_W    = 3,
  parameter int MULT_W   = 3
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                clear,
  input  logic                load_en,
  input  logic [CREDIT_W-1:0] load_value,
  input  logic                bet_req,
  input  logic [BET_W-1:0]    bet_amt,
  input  logic                spin_done,
  input  logic                win,
  input  logic [MULT_W-1:0]   win_mult,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                spin_go,
  output logic                reject,
  output logic                overflow
);

  // Wide enough that credit + bet*mult can never wrap internally.
  localparam int SUM_W = CREDIT_W + BET_W + MULT_W;

  typedef enum logic [1:0] {IDLE, CHARGE, WAIT_SPIN, PAYOUT} state_t;

  state_t              state, state_nx;
  logic [BET_W-1:0]    bet_q, bet_nx;
  logic [MULT_W-1:0]   mult_q, mult_nx;
  logic [CREDIT_W-1:0] credit_nx;
  logic                spin_go_nx, reject_nx, overflow_nx;
  logic [SUM_W-1:0]    sum;
  logic                bet_ok;

  assign sum    = SUM_W'(credit) + SUM_W'(bet_q) * SUM_W'(mult_q);
  assign bet_ok = (bet_amt != '0) && (SUM_W'(bet_amt) <= SUM_W'(credit));
  // Decoded straight from the state register, so no input-to-output path.
  assign busy   = (state != IDLE);

  // Next-state, next-credit and next-pulse decode; clear overrides everything.
  always_comb begin
    state_nx    = state;
    bet_nx      = bet_q;
    mult_nx     = mult_q;
    credit_nx   = credit;
    spin_go_nx  = 1'b0;
    reject_nx   = 1'b0;
    overflow_nx = 1'b0;
    if (clear) begin
      state_nx  = IDLE;
      credit_nx = '0;
      bet_nx    = '0;
      mult_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_en) begin
            credit_nx = load_value;
            reject_nx = bet_req;       // a bet colliding with a load is refused
          end else if (bet_req) begin
            if (bet_ok) begin
              bet_nx     = bet_amt;
              state_nx   = CHARGE;
              spin_go_nx = 1'b1;       // registered, so it is high during CHARGE
            end else begin
              reject_nx  = 1'b1;
            end
          end
        end
        CHARGE: begin
          credit_nx = credit - CREDIT_W'(bet_q);
          reject_nx = bet_req;
          state_nx  = WAIT_SPIN;
        end
        WAIT_SPIN: begin
          reject_nx = bet_req;
          if (spin_done) begin
            if (win) begin
              mult_nx  = win_mult;
              state_nx = PAYOUT;
            end else begin
              state_nx = IDLE;
            end
          end
        end
        PAYOUT: begin
          reject_nx = bet_req;
          state_nx  = IDLE;
          credit_nx = sum[CREDIT_W-1:0];
          if (sum > SUM_W'({CREDIT_W{1'b1}})) begin
            overflow_nx = 1'b1;
`ifdef CREDIT_SAT_EN
            credit_nx   = '1;
`else
            credit_nx   = sum[CREDIT_W-1:0];
`endif
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Credit, latched stake/multiplier and registered output pulses.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      credit   <= '0;
      bet_q    <= '0;
      mult_q   <= '0;
      spin_go  <= 1'b0;
      reject   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      credit   <= credit_nx;
      bet_q    <= bet_nx;
      mult_q   <= mult_nx;
      spin_go  <= spin_go_nx;
      reject   <= reject_nx;
      overflow <= overflow_nx;
    end
  end

endmodule

// File: tb/tb_slot_credit_ledger.sv
// Testbench for slot_credit_ledger (default parameters).
module tb_slot_credit_ledger;
  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       clear    = 1'b0;
  logic       load_en  = 1'b0;
  logic [7:0] load_value = '0;
  logic       bet_req  = 1'b0;
  logic [2:0] bet_amt  = '0;
  logic       spin_done = 1'b0;
  logic       win      = 1'b0;
  logic [2:0] win_mult = '0;
  logic [7:0] credit;
  logic       busy, spin_go, reject, overflow;

  int nerr = 0;
  int nchk = 0;

  slot_credit_ledger dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .clear(clear),
    .load_en(load_en), .load_value(load_value),
    .bet_req(bet_req), .bet_amt(bet_amt),
    .spin_done(spin_done), .win(win), .win_mult(win_mult),
    .credit(credit), .busy(busy), .spin_go(spin_go),
    .reject(reject), .overflow(overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int lv;        // deposit to load first, -1 = keep current credit
    int bet;
    int w;
    int m;
    int acc;       // bet expected to be accepted
    int deb;       // credit after the debit
    int fin;       // credit once the spin is settled
    int ovf;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_load(input int v);
    load_en = 1'b1; load_value = 8'(v);
    step();
    load_en = 1'b0;
    chk("load", int'(credit), v);
  endtask

  task automatic do_spin(input int bet, input int w, input int m, input int acc,
                         input int deb, input int fin, input int ovf, input int wait_cyc);
    bet_req = 1'b1; bet_amt = 3'(bet);
    step();
    bet_req = 1'b0;
    if (acc == 0) begin
      chk("reject", int'(reject), 1);
      chk("rej_no_go", int'(spin_go), 0);
      chk("rej_idle", int'(busy), 0);
      chk("rej_credit", int'(credit), fin);
      step();
      chk("reject_clr", int'(reject), 0);
      return;
    end
    chk("spin_go", int'(spin_go), 1);
    chk("busy_charge", int'(busy), 1);
    chk("acc_no_rej", int'(reject), 0);
    step();
    chk("debit", int'(credit), deb);
    chk("spin_go_clr", int'(spin_go), 0);
    repeat (wait_cyc) step();
    spin_done = 1'b1; win = w[0]; win_mult = 3'(m);
    step();
    spin_done = 1'b0; win = 1'b0;
    if (w == 0) begin
      chk("loss_idle", int'(busy), 0);
      chk("loss_credit", int'(credit), fin);
      return;
    end
    chk("payout_busy", int'(busy), 1);
    chk("payout_hold", int'(credit), deb);
    step();
    chk("payout", int'(credit), fin);
    chk("overflow", int'(overflow), ovf);
    chk("payout_idle", int'(busy), 0);
    step();
    chk("overflow_clr", int'(overflow), 0);
  endtask

  // Reference payout: plain integer arithmetic on the settled balance.
  function automatic int ref_payout(input int deb, input int bet, input int m, output int o);
    int s;
    s = deb + bet * m;
    o = (s > 255) ? 1 : 0;
`ifdef CREDIT_SAT_EN
    return (o != 0) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  vec_t tv[9];

  initial begin
    int mc, op, v, bet, w, m, acc, deb, fin, o;

`ifdef CREDIT_SAT_EN
    tv[4] = '{250, 4, 1, 7, 1, 246, 255, 1};
    tv[8] = '{255, 7, 1, 7, 1, 248, 255, 1};
`else
    tv[4] = '{250, 4, 1, 7, 1, 246, 18, 1};
    tv[8] = '{255, 7, 1, 7, 1, 248, 41, 1};
`endif
    tv[0] = '{20, 3, 0, 0, 1, 17, 17, 0};
    tv[1] = '{-1, 2, 1, 5, 1, 15, 25, 0};
    tv[2] = '{2,  3, 0, 0, 0, 0,  2,  0};
    tv[3] = '{-1, 0, 0, 0, 0, 0,  2,  0};
    tv[5] = '{10, 5, 1, 0, 1, 5,  5,  0};
    tv[6] = '{7,  7, 1, 1, 1, 0,  7,  0};
    tv[7] = '{255, 1, 1, 1, 1, 254, 255, 0};

    // Reset state
    #3;
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_spin_go", int'(spin_go), 0);
    chk("rst_reject", int'(reject), 0);
    chk("rst_overflow", int'(overflow), 0);
    step(); step();
    resetn = 1'b1;
    step();

    // Table-driven spins
    for (int i = 0; i < 9; i++) begin
      if (tv[i].lv >= 0) do_load(tv[i].lv);
      do_spin(tv[i].bet, tv[i].w, tv[i].m, tv[i].acc, tv[i].deb, tv[i].fin, tv[i].ovf, i % 3);
    end

    // spin_done in IDLE is ignored
    do_load(12);
    spin_done = 1'b1; win = 1'b1; win_mult = 3'd7;
    step();
    spin_done = 1'b0; win = 1'b0;
    chk("idle_done_busy", int'(busy), 0);
    step();
    chk("idle_done_credit", int'(credit), 12);

    // Bet/load while busy, then clear in WAIT_SPIN
    do_load(30);
    bet_req = 1'b1; bet_amt = 3'd4;
    step();
    bet_req = 1'b0;
    step();
    chk("seqA_debit", int'(credit), 26);
    load_en = 1'b1; load_value = 8'd99; bet_req = 1'b1; bet_amt = 3'd1;
    step();
    load_en = 1'b0; bet_req = 1'b0;
    chk("busy_reject", int'(reject), 1);
    chk("busy_load_ignored", int'(credit), 26);
    chk("busy_still", int'(busy), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_credit", int'(credit), 0);
    chk("clear_idle", int'(busy), 0);
    chk("clear_no_pulse", int'(reject), 0);
    spin_done = 1'b1; win = 1'b1; win_mult = 3'd3;
    step();
    spin_done = 1'b0; win = 1'b0;
    chk("clr_done_busy", int'(busy), 0);
    step();
    chk("clr_done_credit", int'(credit), 0);
    chk("clr_done_ovf", int'(overflow), 0);

    // resetn during CHARGE, then load+bet in the same cycle
    do_load(30);
    bet_req = 1'b1; bet_amt = 3'd2;
    step();
    bet_req = 1'b0;
    chk("seqB_charge", int'(spin_go), 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_credit", int'(credit), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_spin_go", int'(spin_go), 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    step();
    load_en = 1'b1; load_value = 8'd9; bet_req = 1'b1; bet_amt = 3'd1;
    step();
    load_en = 1'b0; bet_req = 1'b0;
    chk("lb_credit", int'(credit), 9);
    chk("lb_reject", int'(reject), 1);
    chk("lb_no_go", int'(spin_go), 0);
    chk("lb_idle", int'(busy), 0);
    step();
    chk("lb_reject_clr", int'(reject), 0);

    // Randomized transactions against the reference model
    mc = 0;
    for (int i = 0; i < 80; i++) begin
      op = (i == 0) ? 0 : int'($urandom_range(0, 9));
      if (op == 0) begin
        v = int'($urandom_range(0, 255));
        do_load(v);
        mc = v;
      end else if (op == 1) begin
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("rnd_clear", int'(credit), 0);
        mc = 0;
      end else begin
        bet = int'($urandom_range(0, 7));
        w   = int'($urandom_range(0, 1));
        m   = int'($urandom_range(0, 7));
        acc = (bet != 0 && bet <= mc) ? 1 : 0;
        deb = mc - bet;
        o   = 0;
        if (acc == 0)   fin = mc;
        else if (w == 0) fin = deb;
        else            fin = ref_payout(deb, bet, m, o);
        do_spin(bet, w, m, acc, deb, fin, o, int'($urandom_range(0, 3)));
        mc = fin;
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
